// File: rtl/ground_touch_detect.sv
// Ground-contact detector: registered player/block overlap test, per-block debounce FSM
// clocked by the animation tick, and the free-running ipcnt animation counter.
module ground_touch_detect #(
    parameter int NBLK     = 3,
    parameter int BLK_W    = 64,
    parameter int PLY_W    = 32,
    parameter int PLY_H    = 32,
    parameter int FOOT_TOL = 4,
    parameter int TICK_DIV = 6000000,
    parameter int DEBOUNCE = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic [9:0]         player_x,
    input  logic [9:0]         player_y,
    input  logic [NBLK*10-1:0] blk_x,
    input  logic [NBLK*10-1:0] blk_y,
    output logic [31:0]        ipcnt,
    output logic               tick,
    output logic [NBLK-1:0]    contact,
    output logic               on_ground,
    output logic [NBLK-1:0]    bk_touched,
    output logic [NBLK-1:0]    touch_evt
);

    localparam int          CW        = $clog2(DEBOUNCE + 1);
    localparam logic [31:0] TICK_TERM = 32'(TICK_DIV);
    localparam logic [CW:0] DEB_VAL   = (CW + 1)'(DEBOUNCE);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMING  = 2'd1,
        ST_TOUCHED = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Animation counter
    // ------------------------------------------------------------------
    logic [31:0] ipcnt_q, ipcnt_d;
    logic        tick_w;

    assign tick_w  = (ipcnt_q == TICK_TERM);
    assign ipcnt_d = tick_w ? 32'd0 : ipcnt_q + 32'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ipcnt_q <= 32'd0;
        end else begin
            ipcnt_q <= ipcnt_d;
        end
    end

    assign ipcnt = ipcnt_q;
    assign tick  = tick_w;

    // ------------------------------------------------------------------
    // Geometry stage: 11-bit zero-extended so sums never wrap
    // ------------------------------------------------------------------
    logic [10:0]     foot;
    logic [10:0]     px_left;
    logic [10:0]     px_right;
    logic [NBLK-1:0] contact_d;
    logic [NBLK-1:0] contact_q;

    assign foot     = {1'b0, player_y} + 11'(PLY_H);
    assign px_left  = {1'b0, player_x};
    assign px_right = px_left + 11'(PLY_W);

    generate
        for (genvar gi = 0; gi < NBLK; gi++) begin : g_geom
            logic [10:0] bx;
            logic [10:0] by;
            assign bx = {1'b0, blk_x[10*gi +: 10]};
            assign by = {1'b0, blk_y[10*gi +: 10]};
            // Strict inequalities horizontally: sharing an edge is not standing on it.
            assign contact_d[gi] = (foot >= by) && (foot < by + 11'(FOOT_TOL)) &&
                                   (px_left < bx + 11'(BLK_W)) && (px_right > bx);
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            contact_q <= '0;
        end else begin
            contact_q <= contact_d;
        end
    end

    assign contact   = contact_q;
    assign on_ground = |contact_q;

    // ------------------------------------------------------------------
    // Per-block debounce FSM, advanced only on animation ticks
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NBLK; gi++) begin : g_blk
            state_t        state_q, state_d;
            logic [CW-1:0] cnt_q, cnt_d;
            logic [CW:0]   cnt_inc;
            logic          touched_q, touched_d;
            logic          evt_q, evt_d;

            assign cnt_inc = {1'b0, cnt_q} + (CW + 1)'(1);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    state_q   <= ST_IDLE;
                    cnt_q     <= '0;
                    touched_q <= 1'b0;
                    evt_q     <= 1'b0;
                end else begin
                    state_q   <= state_d;
                    cnt_q     <= cnt_d;
                    touched_q <= touched_d;
                    evt_q     <= evt_d;
                end
            end

            // clr outranks a coincident tick so a restart never inherits a latch.
            always_comb begin
                state_d   = state_q;
                cnt_d     = cnt_q;
                touched_d = touched_q;
                evt_d     = 1'b0;
                if (clr) begin
                    state_d   = ST_IDLE;
                    cnt_d     = '0;
                    touched_d = 1'b0;
                end else if (tick_w) begin
                    unique case (state_q)
                        ST_IDLE: begin
                            if (contact_q[gi]) begin
                                cnt_d = CW'(1);
                                if (DEBOUNCE == 1) begin
                                    state_d   = ST_TOUCHED;
                                    touched_d = 1'b1;
                                    evt_d     = 1'b1;
                                end else begin
                                    state_d = ST_ARMING;
                                end
                            end
                        end
                        ST_ARMING: begin
                            if (contact_q[gi]) begin
                                cnt_d = cnt_inc[CW-1:0];
                                if (cnt_inc == DEB_VAL) begin
                                    state_d   = ST_TOUCHED;
                                    touched_d = 1'b1;
                                    evt_d     = 1'b1;
                                end
                            end else begin
                                cnt_d   = '0;
                                state_d = ST_IDLE;
                            end
                        end
                        ST_TOUCHED: begin
                            state_d = ST_TOUCHED;
                        end
                        default: begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                        end
                    endcase
                end
            end

            assign bk_touched[gi] = touched_q;
            assign touch_evt[gi]  = evt_q;
        end
    endgenerate

endmodule

// File: tb/tb_ground_touch_detect.sv
// Directed bench: DEBOUNCE=3 instance for counter/landing/abort/boundary/clr cases,
// DEBOUNCE=1 instance for simultaneous multi-block latching and async reset.
module tb_ground_touch_detect;

    localparam int TD = 9;

    logic        clk = 1'b0;
    logic        rst, clr;
    logic [9:0]  player_x, player_y;
    logic [9:0]  bx0, bx1, bx2, by0, by1, by2;
    logic [29:0] blk_x, blk_y;

    logic [31:0] a_ipcnt, b_ipcnt;
    logic        a_tick, b_tick, a_on_ground, b_on_ground;
    logic [2:0]  a_contact, b_contact, a_bk, b_bk, a_evt, b_evt;

    int total = 0;
    int bad   = 0;
    int ph    = 0;

    assign blk_x = {bx2, bx1, bx0};
    assign blk_y = {by2, by1, by0};

    always #5 clk = ~clk;

    ground_touch_detect #(
        .NBLK(3), .BLK_W(64), .PLY_W(32), .PLY_H(32), .FOOT_TOL(4),
        .TICK_DIV(TD), .DEBOUNCE(3)
    ) dut_a (
        .clk(clk), .rst(rst), .clr(clr),
        .player_x(player_x), .player_y(player_y),
        .blk_x(blk_x), .blk_y(blk_y),
        .ipcnt(a_ipcnt), .tick(a_tick), .contact(a_contact),
        .on_ground(a_on_ground), .bk_touched(a_bk), .touch_evt(a_evt)
    );

    ground_touch_detect #(
        .NBLK(3), .BLK_W(64), .PLY_W(32), .PLY_H(32), .FOOT_TOL(4),
        .TICK_DIV(TD), .DEBOUNCE(1)
    ) dut_b (
        .clk(clk), .rst(rst), .clr(clr),
        .player_x(player_x), .player_y(player_y),
        .blk_x(blk_x), .blk_y(blk_y),
        .ipcnt(b_ipcnt), .tick(b_tick), .contact(b_contact),
        .on_ground(b_on_ground), .bk_touched(b_bk), .touch_evt(b_evt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s val=%0h", tag, got);
        end
    endtask

    // One clock; ph tracks the expected ipcnt independently of the DUT.
    task automatic step();
        @(posedge clk);
        #1;
        ph = (ph == TD) ? 0 : ph + 1;
    endtask

    // Advance through the next clock edge on which tick is high.
    task automatic tick_edge();
        while (ph != TD) step();
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; clr = 1'b0;
        player_x = 10'd0; player_y = 10'd0;
        bx0 = 10'd100; by0 = 10'd200;
        bx1 = 10'd500; by1 = 10'd400;
        bx2 = 10'd800; by2 = 10'd100;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        ph  = 0;

        check("rst_ipcnt", a_ipcnt, 32'd0);
        check("rst_tick", 32'(a_tick), 32'd0);
        check("rst_contact", 32'(a_contact), 32'd0);
        check("rst_on_ground", 32'(a_on_ground), 32'd0);
        check("rst_bk", 32'(a_bk), 32'd0);
        check("rst_evt", 32'(a_evt), 32'd0);

        for (int k = 1; k < 25; k++) begin
            step();
            check($sformatf("ipcnt_clk%0d", k), a_ipcnt, 32'(k % 10));
            check($sformatf("tick_clk%0d", k), 32'(a_tick), 32'((k % 10) == 9));
        end

        // Landing on block0: foot = 168 + 32 = 200
        player_x = 10'd120; player_y = 10'd168;
        step();
        check("land_contact", 32'(a_contact), 32'b001);
        check("land_on_ground", 32'(a_on_ground), 32'd1);
        for (int t = 1; t <= 3; t++) begin
            tick_edge();
            check($sformatf("land_bk_t%0d", t), 32'(a_bk), (t == 3) ? 32'b001 : 32'b000);
            check($sformatf("land_evt_t%0d", t), 32'(a_evt), (t == 3) ? 32'b001 : 32'b000);
        end
        step();
        check("land_evt_drop", 32'(a_evt), 32'd0);
        check("land_bk_hold", 32'(a_bk), 32'b001);

        // Debounce abort after two ticks, then a fresh three-tick landing
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("abort_clr_bk", 32'(a_bk), 32'd0);
        for (int t = 1; t <= 2; t++) begin
            tick_edge();
            check($sformatf("abort_bk_t%0d", t), 32'(a_bk), 32'd0);
        end
        player_y = 10'd150;
        step();
        check("abort_contact", 32'(a_contact), 32'd0);
        tick_edge();
        check("abort_bk_t3", 32'(a_bk), 32'd0);
        check("abort_evt_t3", 32'(a_evt), 32'd0);
        player_y = 10'd168;
        step();
        for (int t = 1; t <= 3; t++) begin
            tick_edge();
            check($sformatf("reland_bk_t%0d", t), 32'(a_bk), (t == 3) ? 32'b001 : 32'b000);
            check($sformatf("reland_evt_t%0d", t), 32'(a_evt), (t == 3) ? 32'b001 : 32'b000);
        end

        // Boundary geometry against block0 at (100,200)
        player_x = 10'd164; player_y = 10'd168; step(); check("bnd_x164", 32'(a_contact), 32'd0);
        player_x = 10'd68;                       step(); check("bnd_x68", 32'(a_contact), 32'd0);
        player_x = 10'd69;                       step(); check("bnd_x69", 32'(a_contact), 32'b001);
        player_x = 10'd163;                      step(); check("bnd_x163", 32'(a_contact), 32'b001);
        player_x = 10'd120; player_y = 10'd171; step(); check("bnd_foot203", 32'(a_contact), 32'b001);
        player_y = 10'd172;                      step(); check("bnd_foot204", 32'(a_contact), 32'd0);
        check("bnd_foot204_og", 32'(a_on_ground), 32'd0);
        player_y = 10'd167;                      step(); check("bnd_foot199", 32'(a_contact), 32'd0);

        // Stickiness while away, then clr on a tick cycle with contact present
        player_y = 10'd100;
        step();
        for (int t = 1; t <= 5; t++) begin
            tick_edge();
            check($sformatf("sticky_bk_t%0d", t), 32'(a_bk), 32'b001);
            check($sformatf("sticky_evt_t%0d", t), 32'(a_evt), 32'd0);
        end
        player_y = 10'd168;
        step();
        while (ph != TD) step();
        check("clr_on_tick_tick", 32'(a_tick), 32'd1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("clr_bk", 32'(a_bk), 32'd0);
        check("clr_evt", 32'(a_evt), 32'd0);
        check("clr_contact_runs", 32'(a_contact), 32'b001);
        for (int t = 1; t <= 3; t++) begin
            tick_edge();
            check($sformatf("postclr_bk_t%0d", t), 32'(a_bk), (t == 3) ? 32'b001 : 32'b000);
        end

        // Multi-block latch on DEBOUNCE=1 instance: blocks 0 and 2 coincide
        bx2 = 10'd100; by2 = 10'd200;
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("multi_clr_bk", 32'(b_bk), 32'd0);
        check("multi_contact", 32'(b_contact), 32'b101);
        check("multi_on_ground", 32'(b_on_ground), 32'd1);
        while (ph != TD) step();
        check("multi_pre_bk", 32'(b_bk), 32'd0);
        step();
        check("multi_bk", 32'(b_bk), 32'b101);
        check("multi_evt", 32'(b_evt), 32'b101);
        step();
        check("multi_evt_drop", 32'(b_evt), 32'd0);
        check("multi_bk_hold", 32'(b_bk), 32'b101);

        // Asynchronous reset mid-run (dut_a is mid-debounce here)
        step(); step();
        rst = 1'b1;
        #1;
        check("arst_a_ipcnt", a_ipcnt, 32'd0);
        check("arst_b_ipcnt", b_ipcnt, 32'd0);
        check("arst_b_bk", 32'(b_bk), 32'd0);
        check("arst_b_evt", 32'(b_evt), 32'd0);
        check("arst_b_contact", 32'(b_contact), 32'd0);
        check("arst_b_on_ground", 32'(b_on_ground), 32'd0);
        check("arst_a_contact", 32'(a_contact), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ph  = 0;
        step();
        check("post_rst_contact", 32'(b_contact), 32'b101);
        check("post_rst_bk", 32'(b_bk), 32'd0);
        check("post_rst_ipcnt", b_ipcnt, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
